// File: rtl/rxuart.sv
// rtl/rxuart.sv - UART receiver: 2-FF sync, per-bit baud counter, 5-8 data bits,
// optional parity, 1/2 stop bits, break detection; one-cycle o_wr strobe per character.
module rxuart #(
    parameter logic [30:0] INITIAL_SETUP = 31'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [30:0] i_setup,
    input  logic        i_uart_rx,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_break,
    output logic        o_ck_uart
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, ck_q, ck_d;
    logic [29:0] setup_q, setup_d;
    logic [23:0] baud_q, baud_d;
    logic [27:0] brk_q, brk_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sreg_q, sreg_d;
    logic        perr_q, perr_d, ferr_q, ferr_d;
    logic        wr_q, wr_d, operr_q, operr_d, oferr_q, oferr_d, break_q, break_d;
    logic [7:0]  data_q, data_d;

    logic [23:0] cpb;
    logic [3:0]  nbits;
    logic        baud_zero, break_hit, frame_bad, par_exp;
    logic        unused_flow;

    assign unused_flow = i_setup[30];
    assign cpb         = setup_q[23:0];
    assign nbits       = 4'd8 - {2'b00, setup_q[29:28]};
    assign baud_zero   = (baud_q == 24'd0);

    always_comb begin
        sync1_d   = i_uart_rx;
        ck_d      = sync1_q;
        state_d   = state_q;
        setup_d   = setup_q;
        baud_d    = baud_zero ? baud_q : baud_q - 24'd1;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        wr_d      = 1'b0;
        data_d    = data_q;
        operr_d   = operr_q;
        oferr_d   = oferr_q;
        frame_bad = ferr_q | ~ck_q;
        par_exp   = setup_q[25] ? setup_q[24] : (setup_q[24] ^ (^sreg_q));

        // Saturating run-length of low line; threshold is 16 baud periods.
        brk_d     = ck_q ? 28'd0 : ((&brk_q) ? brk_q : brk_q + 28'd1);
        break_hit = ~ck_q && (brk_d >= {cpb, 4'h0});
        break_d   = ck_q ? 1'b0 : (break_q | break_hit);

        case (state_q)
            S_WAIT_IDLE: begin
                if (!ck_q)
                    baud_d = cpb - 24'd1;
                else if (baud_zero)
                    state_d = S_IDLE;
            end
            S_IDLE: begin
                setup_d = i_setup[29:0];
                if (!ck_q) begin
                    state_d = S_START;
                    baud_d  = {1'b0, i_setup[23:1]} - 24'd1;
                    bit_d   = 3'd0;
                    sreg_d  = 8'd0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_zero) begin
                    baud_d  = cpb - 24'd1;
                    state_d = ck_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_zero) begin
                    baud_d = cpb - 24'd1;
                    sreg_d = {ck_q, sreg_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if ({1'b0, bit_q} + 4'd1 == nbits)
                        state_d = setup_q[26] ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_zero) begin
                    baud_d  = cpb - 24'd1;
                    perr_d  = perr_q | (ck_q != par_exp);
                    state_d = S_STOP;
                end
            end
            S_STOP, S_STOP2: begin
                if (baud_zero) begin
                    baud_d = cpb - 24'd1;
                    if (state_q == S_STOP && setup_q[27]) begin
                        ferr_d  = frame_bad;
                        state_d = S_STOP2;
                    end else begin
                        // Bits arrived MSB-side first; shift down by the unused width.
                        wr_d    = 1'b1;
                        data_d  = sreg_q >> setup_q[29:28];
                        operr_d = perr_q;
                        oferr_d = frame_bad;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (break_hit) begin
            state_d = S_WAIT_IDLE;
            baud_d  = cpb - 24'd1;
            wr_d    = 1'b0;
            data_d  = data_q;
            operr_d = operr_q;
            oferr_d = oferr_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_WAIT_IDLE;
            sync1_q <= 1'b1;
            ck_q    <= 1'b1;
            setup_q <= INITIAL_SETUP[29:0];
            baud_q  <= INITIAL_SETUP[23:0] - 24'd1;
            brk_q   <= 28'd0;
            bit_q   <= 3'd0;
            sreg_q  <= 8'd0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 8'd0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            break_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            ck_q    <= ck_d;
            setup_q <= setup_d;
            baud_q  <= baud_d;
            brk_q   <= brk_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
            break_q <= break_d;
        end
    end

    assign o_wr         = wr_q;
    assign o_data       = data_q;
    assign o_parity_err = operr_q;
    assign o_frame_err  = oferr_q;
    assign o_break      = break_q;
    assign o_ck_uart    = ck_q;

endmodule

// File: doc/rxuart.md
Name: rxuart

Overview:
- UART receiver; the receive-side counterpart of the existing transmitter.
- Uses the same 31-bit setup word, so one setup register drives both directions.
- Oversamples the serial line with a per-bit baud counter and supports 5–8 data bits, optional parity (even, odd or fixed), 1 or 2 stop bits, and break detection.
- Delivers each received character as a one-cycle strobe with error flags to the bus-side FIFO/register wrapper.

Parameters:
- INITIAL_SETUP, 31'd868: setup word loaded at power-up and on reset (8N1, 868 clocks/baud).

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_setup  input  31  setup word:
  - [30] flow-control disable (ignored by this block)
  - [29:28] data bits: 00=8, 01=7, 10=6, 11=5
  - [27] two stop bits
  - [26] parity enable
  - [25] fixed parity
  - [24] odd parity / fixed parity value
  - [23:0] clocks per baud
- i_uart_rx  input  1  asynchronous serial line, idle high
- o_wr  output  1  one-cycle strobe: o_data and error flags valid
- o_data  output  8  received character, LSB first on the wire, right-aligned, unused upper bits 0
- o_parity_err  output  1  parity mismatch for the character strobed by o_wr
- o_frame_err  output  1  any stop bit sampled low, for the character strobed by o_wr
- o_break  output  1  line held low ≥ 16 baud periods
- o_ck_uart  output  1  synchronized rx line (2-FF)

Behaviour:
- Reset values:
  - o_wr, o_data, o_parity_err, o_frame_err, o_break = 0.
  - Synchronizer flops = 1; o_ck_uart = 1.
  - r_setup = INITIAL_SETUP.
  - State = WAIT_IDLE.
- Reset mid-frame aborts the frame; no o_wr is produced for it.
- Synchronizer: i_uart_rx passes through 2 flops. All logic uses the synchronized value ck.
- States: WAIT_IDLE, IDLE, START, DATA, PARITY, STOP, STOP2.
- WAIT_IDLE: stay until ck has been high for a full baud period (clocks_per_baud consecutive high cycles), then go to IDLE. This state is entered after reset and after a break, so the receiver never starts mid-frame.
- IDLE:
  - r_setup <= i_setup every cycle while in IDLE. The setup is frozen from start detection to frame end.
  - Define T0 as the first cycle with ck=0; go to START.
- START: at T0 + floor(cpb/2), sample ck.
  - Sample 1 is a false start: return to IDLE with no strobe.
  - Sample 0: go to DATA.
- Bit k (start = 0) is sampled at T0 + floor(cpb/2) + k*cpb. The baud counter reloads cpb-1 at each sample and is 24 bits wide; a 28-bit break counter is kept separately.
- DATA:
  - Shift ck into a shift register from the MSB side.
  - After N bits (N from r_setup[29:28]), right-align so that o_data[N-1:0] = the bits received; upper bits are 0.
  - Next state: PARITY if parity is enabled, else STOP.
- PARITY: the expected bit is r_setup[24] if fixed parity is selected, else r_setup[24] XOR (XOR of the data bits). A mismatch latches the parity error.
- STOP: sample ck; 0 latches the frame error. Go to STOP2 if two stop bits are selected, else finish.
- STOP2: sample checked identically to STOP; then finish.
- Finish:
  - o_wr=1 for exactly one cycle, on the cycle after the final stop sample.
  - o_data, o_parity_err and o_frame_err are updated in that same cycle and hold until the next o_wr.
  - Return to IDLE. A new start edge is accepted on the very next cycle; the stop-bit sample point is mid-bit, so back-to-back frames are received.
- Break:
  - An independent 28-bit counter counts consecutive ck=0 cycles and saturates.
  - When the count reaches {cpb,4'h0}, o_break goes to 1 and any frame in progress is abandoned; the state goes to WAIT_IDLE.
  - o_break clears on the first ck=1 cycle.
  - A frame whose stop-bit sample occurs before the break threshold still strobes normally, with o_frame_err=1.
- i_reset has priority over all other events. The break threshold has priority over a simultaneous sample.
- Supported range: cpb ≥ 4; behaviour for smaller values is undefined.

Test Plan:
- Reset, then 8N1 with cpb=16 (i_setup=31'h40000010), line idle 32 cycles, send 0x55 → exactly one o_wr at the cycle after the stop sample (T0+8+9*16+1 after sync), with o_data=0x55 and both error flags 0.
- 7E1 (i_setup=31'h54000010), send 0x41 with parity bit 0 → o_data=0x41, o_parity_err=0. Resend with parity bit 1 → o_parity_err=1, o_data=0x41.
- 8N1, send 0xA5 with stop bit driven low, then release the line → o_wr with o_data=0xA5 and o_frame_err=1. Then send 0x3C → o_data=0x3C, o_frame_err=0.
- 8N1, 5-cycle low glitch (shorter than cpb/2=8) → no o_wr, state back in IDLE. A following 0x81 is received correctly.
- 8N1, line held low for 20*16 cycles → one o_wr with o_data=0x00 and o_frame_err=1; o_break=1 from T0+256; o_break=0 when the line goes high. No byte is accepted until 16 high cycles have elapsed; then 0x7E is received.
- i_setup changed to 5 bits mid-frame → the current frame is still decoded as 8 bits and the change applies to the next frame. i_reset asserted mid-frame → no o_wr, all outputs 0, and the line must be idle before the next reception.
